log_lane_packer: RTL and testbench
==================================

Name: log_lane_packer

Overview:
- Upstream feeder of the 4-entry, 288-bit log FIFO.
- Accepts 72-bit log lanes over a valid/ready handshake and packs four of them into one 288-bit word.
- Issues a single-cycle write strobe with the word.
- The FIFO has no full flag, so this block tracks FIFO occupancy itself from the consumer's read strobe and never writes into a full FIFO.

Parameters:
- LANE_W, 72, width of one log lane.
- LANES, 4, lanes per FIFO word; write_dt width = LANE_W*LANES.
- width_adr, 2, FIFO address width; DEPTH = 2**width_adr = 4.
- PAD, 72'h0, value written into unfilled lanes on flush.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  lane offered.
- in_data  in  LANE_W  lane payload.
- in_ready  out  1  lane accepted when in_valid && in_ready at a rising edge.
- flush  in  1  close a partial word (pad the rest and write it).
- fifo_read_en  in  1  the FIFO consumer's read strobe, observed for occupancy.
- write_en  out  1  FIFO write strobe.
- write_dt  out  LANE_W*LANES  packed word.
- occ  out  width_adr+1  current FIFO occupancy, 0..DEPTH.
- rd_err  out  1  sticky; set when fifo_read_en arrives with occ==0.

Behaviour:
- Reset (asynchronous, takes effect mid-operation):
  - state=FILL, lane_cnt=0, assembly register=0, occ=0, rd_err=0, write_en=0, write_dt=0, in_ready=1.
  - Any partial word is discarded.
  - System reset must also leave the FIFO pointers equal (empty FIFO).
- Packing:
  - The lane accepted with lane_cnt=k goes to bits [k*LANE_W +: LANE_W]; lane 0 is the LSBs.
  - lane_cnt counts 0..LANES-1.
- States: FILL, HOLD, WRITE.
- FILL:
  - in_ready=1.
  - On accepting the lane that completes the word (lane_cnt==LANES-1): go to WRITE if occ<DEPTH, else HOLD.
  - flush with lane_cnt>0 and no accept: remaining lanes are set to PAD, then same WRITE/HOLD choice.
  - flush together with an accept: the lane is placed first, then the remaining lanes are padded.
  - flush with lane_cnt==0 and no accept: ignored.
- HOLD:
  - in_ready=0; the word is frozen.
  - Go to WRITE on the first cycle with occ<DEPTH.
- WRITE:
  - write_en=1 for exactly one cycle; write_dt holds the packed word.
  - Then return to FILL with lane_cnt=0 and the assembly register cleared.
  - in_ready=0 in WRITE.
- Latency and throughput: the last lane accepted at edge N gives write_en high during cycle N..N+1 when space exists. Steady-state throughput is 4 lanes per 5 cycles.
- write_dt is registered and holds its value outside WRITE.
- Occupancy update each edge:
  - occ += write_en.
  - occ -= (fifo_read_en && occ>0).
  - Simultaneous write and read leave occ unchanged.
- occ never exceeds DEPTH; write_en is never asserted with occ==DEPTH.
- Underflow: fifo_read_en with occ==0 leaves occ at 0 and sets rd_err, which stays set until reset.
- FIFO address wrap is implicit. occ is one bit wider than width_adr so that full (4) and empty (0) are distinguished.

Decomposition:
- Shared package holds:
  - LANE_W, LANES, DEPTH constants.
  - State enum: FILL=2'd0, HOLD=2'd1, WRITE=2'd2.
  - PAD default.
- One sub-module is natural: fifo_occ_counter.
  - Inputs: clk, rst, inc=write_en, dec=fifo_read_en.
  - Outputs: occ, rd_err.
  - Saturating up/down counter 0..DEPTH.

Test Plan:
- Reset, then 4 lanes 72'h1, 72'h2, 72'h3, 72'h4 on consecutive cycles, no reads -> one write_en pulse one cycle after the 4th accept; write_dt = {72'h4, 72'h3, 72'h2, 72'h1}; occ=1.
- 16 lanes streamed, no reads -> 4 writes; occ=4. A 5th group of 4 lanes -> HOLD, in_ready=0, write_en stays 0. One fifo_read_en pulse -> occ=3, then write_en the next cycle, occ=4.
- 2 lanes (72'hA, 72'hB) then flush -> write_dt = {PAD, PAD, 72'hB, 72'hA}. flush asserted with lane_cnt==0 -> no write.
- Flush in the same cycle as the 3rd lane -> lanes 0..2 carry data, lane 3 = PAD, single write.
- fifo_read_en at occ=0 -> occ stays 0 and rd_err=1 sticky. Simultaneous write_en and fifo_read_en at occ=2 -> occ stays 2.
- rst asserted mid-word after 3 lanes -> all outputs immediately at reset values. The next 4 lanes form a clean word with no stale data.

Source files
------------

// File: rtl/log_lane_packer_pkg.sv
// Shared constants and FSM encoding for the log lane packer.
package log_lane_packer_pkg;

  localparam int unsigned LANE_W    = 72;
  localparam int unsigned LANES     = 4;
  localparam int unsigned WORD_W    = LANE_W * LANES;
  localparam int unsigned WIDTH_ADR = 2;
  localparam int unsigned DEPTH     = 2 ** WIDTH_ADR;
  localparam int unsigned OCC_W     = WIDTH_ADR + 1;
  localparam int unsigned CNT_W     = $clog2(LANES);

  localparam logic [LANE_W-1:0] PAD = 72'h0;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/log_lane_packer_fifo_occ_counter.sv
// Shadow occupancy of the downstream log FIFO, which has no full flag.
// Saturating 0..DEPTH up/down counter with a sticky underflow flag.
module fifo_occ_counter
  import log_lane_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] occ,
  output logic             rd_err
);

  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic             dec_ok;
  logic             inc_ok;
  logic [OCC_W-1:0] occ_next;

  // A read on an empty FIFO is not counted; a write on a full one cannot happen.
  always_comb begin
    dec_ok   = dec && (occ != '0);
    inc_ok   = inc && ((occ != FULL) || dec_ok);
    occ_next = occ;
    if (inc_ok && !dec_ok) begin
      occ_next = occ + OCC_W'(1);
    end else if (dec_ok && !inc_ok) begin
      occ_next = occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      rd_err <= 1'b0;
    end else begin
      occ <= occ_next;
      if (dec && (occ == '0)) begin
        rd_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/log_lane_packer.sv
// Packs four 72-bit log lanes into one 288-bit FIFO word and writes it,
// holding the word back while the shadow occupancy says the FIFO is full.
module log_lane_packer
  import log_lane_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic              fifo_read_en,
  output logic              write_en,
  output logic [WORD_W-1:0] write_dt,
  output logic [OCC_W-1:0]  occ,
  output logic              rd_err
);

  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  lane_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_next;
  logic              accept;
  logic              flush_close;
  logic              close;
  logic              has_space;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next state, lane placement and flush padding.
  always_comb begin
    state_next  = state;
    cnt_next    = lane_cnt;
    asm_next    = asm_q;
    accept      = in_valid && in_ready;
    flush_close = 1'b0;
    close       = 1'b0;
    has_space   = (occ < FULL);
    case (state)
      FILL: begin
        flush_close = flush && (accept || (lane_cnt != '0));
        for (int unsigned i = 0; i < LANES; i++) begin
          if (accept && (CNT_W'(i) == lane_cnt)) begin
            asm_next[i*LANE_W +: LANE_W] = in_data;
          end
          // Pad everything above the last filled lane.
          if (flush_close && ((CNT_W'(i) > lane_cnt) || ((CNT_W'(i) == lane_cnt) && !accept))) begin
            asm_next[i*LANE_W +: LANE_W] = PAD;
          end
        end
        if (accept) begin
          cnt_next = lane_cnt + CNT_W'(1);
        end
        close = (accept && (lane_cnt == CNT_W'(LANES - 1))) || flush_close;
        if (close) begin
          cnt_next   = '0;
          state_next = has_space ? WRITE : HOLD;
        end
      end
      HOLD: begin
        if (has_space) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = FILL;
        cnt_next   = '0;
        asm_next   = '0;
      end
      default: begin
        state_next = FILL;
        cnt_next   = '0;
        asm_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt <= '0;
      asm_q    <= '0;
      in_ready <= 1'b1;
      write_en <= 1'b0;
      write_dt <= '0;
    end else begin
      lane_cnt <= cnt_next;
      asm_q    <= asm_next;
      in_ready <= (state_next == FILL);
      write_en <= (state_next == WRITE);
      if (state_next == WRITE) begin
        write_dt <= asm_next;
      end
    end
  end

  fifo_occ_counter u_occ (
    .clk    (clk),
    .rst    (rst),
    .inc    (write_en),
    .dec    (fifo_read_en),
    .occ    (occ),
    .rd_err (rd_err)
  );

endmodule

// File: tb/tb_log_lane_packer.sv
// Self-checking bench for log_lane_packer: vector table, directed multi-cycle
// sequences and a randomized run against a queue-based reference model.
module tb_log_lane_packer;

  localparam logic [71:0] PAD_L = 72'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [71:0]  in_data = '0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic         fifo_read_en = 1'b0;
  logic         write_en;
  logic [287:0] write_dt;
  logic [2:0]   occ;
  logic         rd_err;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_count = 0;

  log_lane_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .flush        (flush),
    .fifo_read_en (fifo_read_en),
    .write_en     (write_en),
    .write_dt     (write_dt),
    .occ          (occ),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (write_en === 1'b1) wr_count <= wr_count + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; fifo_read_en = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_wen", write_en, 0);
    chk("rst_dt", write_dt, 0);
    chk("rst_occ", occ, 0);
    chk("rst_err", rd_err, 0);
    cyc();
    rst = 1'b0;
  endtask

  // Offer one lane and wait (bounded) until it is taken.
  task automatic push(input logic [71:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("push_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [71:0]  mq[$];
  bit           m_pend, m_wen, m_err, m_ready;
  logic [287:0] m_word, m_dt;
  int           m_occ;

  function automatic void model_reset();
    mq.delete();
    m_pend = 0; m_wen = 0; m_err = 0; m_ready = 1;
    m_word = '0; m_dt = '0; m_occ = 0;
  endfunction

  function automatic void model_step(bit v, logic [71:0] d, bit f, bit r);
    bit acc = v && m_ready;
    int occ0 = m_occ;
    if (r && occ0 == 0) m_err = 1;
    m_occ = occ0 + (m_wen ? 1 : 0) - ((r && occ0 > 0) ? 1 : 0);
    if (m_wen) begin
      m_wen  = 0;
      m_pend = 0;
    end else if (m_pend) begin
      if (occ0 < 4) begin m_wen = 1; m_dt = m_word; end
    end else begin
      if (acc) mq.push_back(d);
      if (mq.size() == 4 || (f && mq.size() > 0)) begin
        for (int i = 0; i < 4; i++) m_word[i*72 +: 72] = (i < mq.size()) ? mq[i] : PAD_L;
        mq.delete();
        m_pend = 1;
        if (occ0 < 4) begin m_wen = 1; m_dt = m_word; end
      end
    end
    m_ready = !m_pend;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit v; logic [71:0] d; bit f; bit r;
    bit e_ready; bit e_wen; int e_occ; bit e_err; bit chk_dt; logic [287:0] e_dt;
  } vec_t;

  function automatic vec_t mk(bit v, logic [71:0] d, bit f, bit r, bit er, bit ew,
                              int eo, bit ee, bit cd, logic [287:0] edt);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.r = r; t.e_ready = er; t.e_wen = ew;
    t.e_occ = eo; t.e_err = ee; t.chk_dt = cd; t.e_dt = edt;
    return t;
  endfunction

  vec_t tbl[18];

  initial begin
    logic [71:0] rdat;
    int wr0;
    bit rv, rf, rr;

    //          v  data   f  r  rdy wen occ err cdt expected word
    tbl[0]  = mk(1, 72'h1, 0, 0, 1, 0, 0, 0, 0, '0);
    tbl[1]  = mk(1, 72'h2, 0, 0, 1, 0, 0, 0, 0, '0);
    tbl[2]  = mk(1, 72'h3, 0, 0, 1, 0, 0, 0, 0, '0);
    tbl[3]  = mk(1, 72'h4, 0, 0, 0, 1, 0, 0, 1, {72'h4, 72'h3, 72'h2, 72'h1});
    tbl[4]  = mk(0, 72'h0, 0, 0, 1, 0, 1, 0, 1, {72'h4, 72'h3, 72'h2, 72'h1});
    tbl[5]  = mk(1, 72'hA, 0, 0, 1, 0, 1, 0, 0, '0);
    tbl[6]  = mk(1, 72'hB, 0, 0, 1, 0, 1, 0, 0, '0);
    tbl[7]  = mk(0, 72'h0, 1, 0, 0, 1, 1, 0, 1, {PAD_L, PAD_L, 72'hB, 72'hA});
    tbl[8]  = mk(0, 72'h0, 1, 0, 1, 0, 2, 0, 0, '0);
    tbl[9]  = mk(0, 72'h0, 1, 0, 1, 0, 2, 0, 1, {PAD_L, PAD_L, 72'hB, 72'hA});
    tbl[10] = mk(1, 72'h5, 0, 0, 1, 0, 2, 0, 0, '0);
    tbl[11] = mk(1, 72'h6, 0, 0, 1, 0, 2, 0, 0, '0);
    tbl[12] = mk(1, 72'h7, 1, 0, 0, 1, 2, 0, 1, {PAD_L, 72'h7, 72'h6, 72'h5});
    tbl[13] = mk(0, 72'h0, 0, 1, 1, 0, 2, 0, 0, '0);
    tbl[14] = mk(0, 72'h0, 0, 1, 1, 0, 1, 0, 0, '0);
    tbl[15] = mk(0, 72'h0, 0, 1, 1, 0, 0, 0, 0, '0);
    tbl[16] = mk(0, 72'h0, 0, 1, 1, 0, 0, 1, 0, '0);
    tbl[17] = mk(0, 72'h0, 0, 0, 1, 0, 0, 1, 0, '0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; flush = tbl[i].f; fifo_read_en = tbl[i].r;
      cyc();
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_wen", i), write_en, tbl[i].e_wen);
      chk($sformatf("tbl%0d_occ", i), occ, 288'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_err", i), rd_err, tbl[i].e_err);
      if (tbl[i].chk_dt) chk($sformatf("tbl%0d_dt", i), write_dt, tbl[i].e_dt);
    end
    in_valid = 0; flush = 0; fifo_read_en = 0;

    // Fill the FIFO, then back-pressure into HOLD and release with one read.
    do_reset();
    wr0 = wr_count;
    for (int i = 0; i < 16; i++) push(72'(i + 16));
    cyc();
    chk("fill_writes", 288'(wr_count - wr0), 4);
    chk("fill_occ", occ, 4);
    for (int i = 0; i < 4; i++) push(72'h50 + 72'(i));
    chk("hold_ready", in_ready, 0);
    chk("hold_wen", write_en, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_wait_wen", write_en, 0);
      chk("hold_wait_ready", in_ready, 0);
      chk("hold_wait_occ", occ, 4);
    end
    fifo_read_en = 1'b1;
    cyc();
    fifo_read_en = 1'b0;
    chk("rel_occ", occ, 3);
    chk("rel_wen0", write_en, 0);
    cyc();
    chk("rel_wen", write_en, 1);
    chk("rel_dt", write_dt, {72'h53, 72'h52, 72'h51, 72'h50});
    cyc();
    chk("rel_occ_full", occ, 4);
    chk("rel_wen_done", write_en, 0);
    chk("rel_ready", in_ready, 1);

    // Asynchronous reset in the middle of a word.
    for (int i = 0; i < 3; i++) push(72'hDEAD_0000 + 72'(i));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_wen", write_en, 0);
    chk("arst_dt", write_dt, 0);
    chk("arst_occ", occ, 0);
    chk("arst_err", rd_err, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(72'h11 + 72'(i));
    chk("post_rst_wen", write_en, 1);
    chk("post_rst_dt", write_dt, {72'h14, 72'h13, 72'h12, 72'h11});
    chk("post_rst_occ", occ, 0);

    // Randomized run against the reference model, with one reset midway.
    do_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        do_reset();
        model_reset();
      end
      rv   = ($urandom_range(0, 9) < 7);
      rf   = ($urandom_range(0, 9) == 0);
      rr   = ($urandom_range(0, 9) < 3);
      rdat = {8'($urandom), $urandom, $urandom};
      in_valid = rv; in_data = rdat; flush = rf; fifo_read_en = rr;
      cyc();
      model_step(rv, rdat, rf, rr);
      chk("rnd_ready", in_ready, m_ready);
      chk("rnd_wen", write_en, m_wen);
      chk("rnd_dt", write_dt, m_dt);
      chk("rnd_occ", occ, 288'(m_occ));
      chk("rnd_err", rd_err, m_err);
    end
    in_valid = 0; flush = 0; fifo_read_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
